// File: rtl/if_fetch_unit_if.sv
// Instruction SRAM port bundle between the fetch stage (master) and the SRAM (slave).
interface if_fetch_unit_if;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;

   modport master (
      output inst_sram_en,
      output inst_sram_wen,
      output inst_sram_addr,
      output inst_sram_wdata,
      input  inst_sram_rdata
   );

   modport slave (
      input  inst_sram_en,
      input  inst_sram_wen,
      input  inst_sram_addr,
      input  inst_sram_wdata,
      output inst_sram_rdata
   );
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage of the 5-stage MIPS pipeline: PC register, instruction SRAM request,
// branch redirect (held across stalls) and a 1-entry buffer for the fetched word.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
   parameter int unsigned STALL_W  = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic [32:0]        br_bus,
   if_fetch_unit_if.master    sram,
   output logic [32:0]        if_to_id_bus,
   output logic [31:0]        id_inst,
   output logic               fetch_adel
);

   localparam logic STOP = 1'b1;

   logic        br_e;
   logic [31:0] br_addr;
   logic [31:0] pc_reg;
   logic        ce_reg;
   logic        redir_v;
   logic [31:0] redir_addr;
   logic        buf_v;
   logic [31:0] buf_inst;
   logic        rd_v;
   logic        ce_in_id;
   logic [31:0] next_pc;
   logic        unused_stall;

   assign br_e         = br_bus[32];
   assign br_addr      = br_bus[31:0];
   assign unused_stall = ^stall[STALL_W-1:3];

   // Next fetch address: a held redirect beats a fresh branch, which beats sequential fetch.
   always_comb begin
      next_pc = pc_reg + 32'd4;
      if (redir_v)
         next_pc = redir_addr;
      else if (br_e)
         next_pc = br_addr;
   end

   // PC advance; branches seen while the PC is held are parked until the stall ends.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg     <= RESET_PC;
         ce_reg     <= 1'b0;
         redir_v    <= 1'b0;
         redir_addr <= '0;
      end else if (stall[0] != STOP) begin
         pc_reg  <= next_pc;
         ce_reg  <= 1'b1;
         redir_v <= 1'b0;
      end else if (br_e) begin
         redir_v    <= 1'b1;
         redir_addr <= br_addr;
      end
   end

   // Tracks whether the SRAM data port carries a fresh word this cycle.
   always_ff @(posedge clk) begin
      if (rst)
         rd_v <= 1'b0;
      else
         rd_v <= sram.inst_sram_en;
   end

   // Capture the first fresh word of an IF/ID stall; releasing the stall drops it.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_v    <= 1'b0;
         buf_inst <= '0;
      end else if (stall[1] != STOP) begin
         buf_v <= 1'b0;
      end else if (rd_v && !buf_v) begin
         buf_v    <= 1'b1;
         buf_inst <= sram.inst_sram_rdata;
      end
   end

   // Valid flag of the instruction in ID: follows ce_reg on advance, bubbles when ID proceeds alone.
   always_ff @(posedge clk) begin
      if (rst)
         ce_in_id <= 1'b0;
      else if (stall[1] == STOP && stall[2] != STOP)
         ce_in_id <= 1'b0;
      else if (stall[1] != STOP)
         ce_in_id <= ce_reg;
   end

   assign sram.inst_sram_en    = ce_reg & ~stall[0];
   assign sram.inst_sram_wen   = '0;
   assign sram.inst_sram_addr  = pc_reg;
   assign sram.inst_sram_wdata = '0;

   assign if_to_id_bus = {ce_reg, pc_reg};
   assign id_inst      = !ce_in_id ? '0 : (buf_v ? buf_inst : sram.inst_sram_rdata);
   assign fetch_adel   = ce_reg & (pc_reg[1:0] != 2'b00);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a 1-cycle-latency instruction SRAM model.
module tb_if_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;
   localparam logic [31:0] GARBAGE  = 32'hDEAD_BEEF;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic [32:0] br_bus;
   logic [32:0] if_to_id_bus;
   logic [31:0] id_inst;
   logic        fetch_adel;
   logic        garbage_mode;

   int checks;
   int errors;

   if_fetch_unit_if sram ();

   if_fetch_unit #(
      .RESET_PC (RESET_PC),
      .STALL_W  (6)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .br_bus       (br_bus),
      .sram         (sram.master),
      .if_to_id_bus (if_to_id_bus),
      .id_inst      (id_inst),
      .fetch_adel   (fetch_adel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // SRAM model: registered read; when idle it either holds or returns garbage.
   always @(posedge clk) begin
      if (sram.inst_sram_en)
         sram.inst_sram_rdata <= model_word(sram.inst_sram_addr);
      else if (garbage_mode)
         sram.inst_sram_rdata <= GARBAGE;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      stall        = '0;
      br_bus       = '0;
      garbage_mode = 1'b0;
      sram.inst_sram_rdata = '0;

      // T1 reset
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t1_bus", if_to_id_bus, {1'b0, RESET_PC});
         check("t1_en", {32'd0, sram.inst_sram_en}, 33'd0);
         check("t1_id_inst", {1'b0, id_inst}, 33'd0);
         check("t1_adel", {32'd0, fetch_adel}, 33'd0);
      end
      rst = 1'b0;
      tick();
      check("t1_first_addr", {1'b0, sram.inst_sram_addr}, {1'b0, 32'hBFC0_0000});
      check("t1_first_ce", {32'd0, if_to_id_bus[32]}, 33'd1);
      check("t1_wen", {29'd0, sram.inst_sram_wen}, 33'd0);
      check("t1_wdata", {1'b0, sram.inst_sram_wdata}, 33'd0);

      // T2 sequential fetch
      for (int i = 0; i < 5; i++) begin
         check("t2_addr", {1'b0, sram.inst_sram_addr}, {1'b0, 32'hBFC0_0000 + 32'(4 * i)});
         check("t2_en", {32'd0, sram.inst_sram_en}, 33'd1);
         check("t2_id_inst", {1'b0, id_inst},
               {1'b0, (i == 0) ? 32'd0 : model_word(32'hBFC0_0000 + 32'(4 * (i - 1)))});
         check("t2_adel", {32'd0, fetch_adel}, 33'd0);
         tick();
      end

      // T3 branch with delay slot
      do_reset();
      tick();
      tick();
      br_bus = {1'b1, 32'hBFC0_0100};
      #1;
      check("t3_addr_at_branch", {1'b0, sram.inst_sram_addr}, {1'b0, 32'hBFC0_0008});
      tick();
      br_bus = '0;
      check("t3_target", {1'b0, sram.inst_sram_addr}, {1'b0, 32'hBFC0_0100});
      check("t3_delay_slot", {1'b0, id_inst}, {1'b0, model_word(32'hBFC0_0008)});
      tick();
      check("t3_target_plus4", {1'b0, sram.inst_sram_addr}, {1'b0, 32'hBFC0_0104});
      check("t3_target_inst", {1'b0, id_inst}, {1'b0, model_word(32'hBFC0_0100)});

      // T4 redirect arriving during a stall, plus a competing branch in the release cycle
      stall = 6'b000011;
      #1;
      check("t4_c1_en", {32'd0, sram.inst_sram_en}, 33'd0);
      check("t4_c1_addr", {1'b0, sram.inst_sram_addr}, {1'b0, 32'hBFC0_0104});
      tick();
      br_bus = {1'b1, 32'hBFC0_0200};
      check("t4_c2_addr", {1'b0, sram.inst_sram_addr}, {1'b0, 32'hBFC0_0104});
      tick();
      br_bus = '0;
      check("t4_c3_addr", {1'b0, sram.inst_sram_addr}, {1'b0, 32'hBFC0_0104});
      check("t4_c3_en", {32'd0, sram.inst_sram_en}, 33'd0);
      tick();
      check("t4_c4_addr", {1'b0, sram.inst_sram_addr}, {1'b0, 32'hBFC0_0104});
      tick();
      stall  = '0;
      br_bus = {1'b1, 32'hBFC0_0400};
      #1;
      check("t4_release_addr", {1'b0, sram.inst_sram_addr}, {1'b0, 32'hBFC0_0104});
      check("t4_release_en", {32'd0, sram.inst_sram_en}, 33'd1);
      tick();
      br_bus = '0;
      check("t4_redirect_addr", {1'b0, sram.inst_sram_addr}, {1'b0, 32'hBFC0_0200});
      check("t4_id_inst", {1'b0, id_inst}, {1'b0, model_word(32'hBFC0_0104)});
      tick();
      check("t4_redirect_plus4", {1'b0, sram.inst_sram_addr}, {1'b0, 32'hBFC0_0204});

      // T5 instruction buffer holds the word while the SRAM returns garbage
      garbage_mode = 1'b1;
      stall = 6'b000111;
      #1;
      check("t5_c1_id_inst", {1'b0, id_inst}, {1'b0, model_word(32'hBFC0_0200)});
      tick();
      check("t5_c2_id_inst", {1'b0, id_inst}, {1'b0, model_word(32'hBFC0_0200)});
      check("t5_c2_buf_v", {32'd0, dut.buf_v}, 33'd1);
      tick();
      check("t5_c3_id_inst", {1'b0, id_inst}, {1'b0, model_word(32'hBFC0_0200)});
      tick();
      stall = '0;
      #1;
      check("t5_release_id_inst", {1'b0, id_inst}, {1'b0, model_word(32'hBFC0_0200)});
      tick();
      garbage_mode = 1'b0;
      check("t5_buf_v_cleared", {32'd0, dut.buf_v}, 33'd0);
      check("t5_next_id_inst", {1'b0, id_inst}, {1'b0, model_word(32'hBFC0_0204)});
      check("t5_next_addr", {1'b0, sram.inst_sram_addr}, {1'b0, 32'hBFC0_0208});

      // T6 reset while a redirect and a buffered word are pending
      stall  = 6'b000111;
      br_bus = {1'b1, 32'hBFC0_0300};
      tick();
      br_bus = '0;
      check("t6_redir_set", {32'd0, dut.redir_v}, 33'd1);
      check("t6_buf_set", {32'd0, dut.buf_v}, 33'd1);
      rst = 1'b1;
      tick();
      check("t6_redir_cleared", {32'd0, dut.redir_v}, 33'd0);
      check("t6_buf_cleared", {32'd0, dut.buf_v}, 33'd0);
      check("t6_bus", if_to_id_bus, {1'b0, RESET_PC});
      check("t6_id_inst", {1'b0, id_inst}, 33'd0);
      rst   = 1'b0;
      stall = '0;
      tick();
      check("t6_first_fetch", if_to_id_bus, {1'b1, 32'hBFC0_0000});
      tick();
      check("t6_second_fetch", {1'b0, sram.inst_sram_addr}, {1'b0, 32'hBFC0_0004});

      // T7 misaligned target is fetched and flagged; PC wraps at the top of memory
      br_bus = {1'b1, 32'hBFC0_0302};
      tick();
      br_bus = '0;
      check("t7_misaligned_addr", {1'b0, sram.inst_sram_addr}, {1'b0, 32'hBFC0_0302});
      check("t7_adel", {32'd0, fetch_adel}, 33'd1);
      tick();
      check("t7_misaligned_plus4", {1'b0, sram.inst_sram_addr}, {1'b0, 32'hBFC0_0306});
      br_bus = {1'b1, 32'hFFFF_FFFC};
      tick();
      br_bus = '0;
      check("t7_top_addr", {1'b0, sram.inst_sram_addr}, {1'b0, 32'hFFFF_FFFC});
      check("t7_top_adel", {32'd0, fetch_adel}, 33'd0);
      tick();
      check("t7_wrap_addr", {1'b0, sram.inst_sram_addr}, 33'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
